// File: rtl/lpc_capture_pkg.sv
// lpc_capture_pkg: shared widths, the queued record layout, the frame
// serializer state encoding and the frame byte selector used by the
// LPC capture scheduler.
package lpc_capture_pkg;

  localparam int CTDIR_W   = 4;
  localparam int SIZE_W    = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int DROP_W    = 8;
  localparam int REC_W     = CTDIR_W + SIZE_W + ADDR_W + DATA_W + DROP_W; // 80
  localparam int FRAME_LEN = 11;
  localparam int IDX_W     = 4;

  typedef struct packed {
    logic [CTDIR_W-1:0] ctdir;
    logic [SIZE_W-1:0]  size;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [DROP_W-1:0]  drops;
  } rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Byte idx of a frame built from record r. Multi-byte fields go out MSB first.
  function automatic logic [7:0] frame_byte(input rec_t r, input logic [IDX_W-1:0] idx,
                                            input logic [7:0] sync);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = sync;
      4'd1:    b = {r.ctdir, r.size};
      4'd2:    b = r.addr[31:24];
      4'd3:    b = r.addr[23:16];
      4'd4:    b = r.addr[15:8];
      4'd5:    b = r.addr[7:0];
      4'd6:    b = r.data[31:24];
      4'd7:    b = r.data[23:16];
      4'd8:    b = r.data[15:8];
      4'd9:    b = r.data[7:0];
      4'd10:   b = r.drops;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpc_capture_scheduler_fifo.sv
// lpc_rec_fifo: synchronous first-word-fall-through FIFO for capture records.
//  lpc_clock / lpc_reset : clock, async active-low clear (pointers and level)
//  push / din            : write din when push and not full
//  pop  / dout           : dout is the head entry; pop discards it when not empty
//  full / empty / level  : occupancy, all derived from registered state
module lpc_rec_fifo
  import lpc_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REC_W
) (
  input  logic                       lpc_clock,
  input  logic                       lpc_reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge lpc_clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/lpc_capture_scheduler.sv
// lpc_capture_scheduler: filters decoded LPC cycle records, queues them and
// streams each as an 11-byte frame (sync, ctdir/size, addr, data, drops) over
// a valid/ready byte link.
//  lpc_clock, lpc_reset          : clock, async active-low reset
//  in_strobe + in_* fields       : one record per strobe cycle
//  cfg_enable, cfg_ctdir_mask    : accept gate and per-cycle-type filter
//  out_valid/out_byte/out_ready  : frame byte stream
//  stat_level/overflow/busy      : FIFO occupancy, sticky loss flag, activity
module lpc_capture_scheduler
  import lpc_capture_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'h5A
) (
  input  logic                          lpc_clock,
  input  logic                          lpc_reset,
  input  logic                          in_strobe,
  input  logic [CTDIR_W-1:0]            in_cyctype_dir,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [SIZE_W-1:0]             in_data_size,
  input  logic                          cfg_enable,
  input  logic [15:0]                   cfg_ctdir_mask,
  output logic                          out_valid,
  output logic [7:0]                    out_byte,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   stat_level,
  output logic                          stat_overflow,
  output logic                          stat_busy
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  rec_t              frame;
  rec_t              fifo_din;
  logic [REC_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              drop;
  logic              pop;
  logic              load;
  logic [DROP_W-1:0] drop_cnt;

  // Full comes from the registered level: a pop this cycle does not make room.
  assign accept = in_strobe && cfg_enable && cfg_ctdir_mask[in_cyctype_dir];
  assign push   = accept && !fifo_full;
  assign drop   = accept && fifo_full;

  assign fifo_din = '{ctdir: in_cyctype_dir, size: in_data_size, addr: in_addr,
                      data: in_data, drops: drop_cnt};

  lpc_rec_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REC_W)) u_fifo (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .push      (push),
    .din       (fifo_din),
    .pop       (pop),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (stat_level)
  );

  // Drop counter travels with the next stored record, so it clears on push.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      drop_cnt      <= '0;
      stat_overflow <= 1'b0;
    end else if (push) begin
      drop_cnt <= '0;
    end else if (drop) begin
      stat_overflow <= 1'b1;
      if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      frame <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load) frame <= rec_t'(fifo_dout);
    end
  end

  // Serializer: on the last byte's handshake the next record is loaded
  // directly so back-to-back frames have no idle gap.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pop       = 1'b0;
    load      = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          idx_n   = '0;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_byte  = frame_byte(frame, idx, SYNC_BYTE);
        if (out_ready) begin
          if (idx == IDX_W'(FRAME_LEN - 1)) begin
            idx_n = '0;
            if (!fifo_empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign stat_busy = (state == ST_SEND) || (stat_level != '0);

endmodule

// File: tb/tb_lpc_capture_scheduler.sv
module tb_lpc_capture_scheduler;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        in_strobe;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_data_size;
  logic        cfg_enable;
  logic [15:0] cfg_ctdir_mask;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready;
  logic [2:0]  stat_level;
  logic        stat_overflow;
  logic        stat_busy;

  int tests = 0;
  int fails = 0;
  int nbytes = 0;
  logic [7:0] exp_q[$];

  always #5 lpc_clock = ~lpc_clock;

  lpc_capture_scheduler dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .in_strobe      (in_strobe),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .cfg_enable     (cfg_enable),
    .cfg_ctdir_mask (cfg_ctdir_mask),
    .out_valid      (out_valid),
    .out_byte       (out_byte),
    .out_ready      (out_ready),
    .stat_level     (stat_level),
    .stat_overflow  (stat_overflow),
    .stat_busy      (stat_busy)
  );

  typedef struct {
    logic [3:0]  ct;
    logic [15:0] mask;
    logic        en;
    logic        acc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] ct, input logic [3:0] sz,
                            input logic [31:0] a, input logic [31:0] d, input logic [7:0] dr);
    exp_q.push_back(8'h5A);
    exp_q.push_back({ct, sz});
    for (int i = 3; i >= 0; i--) exp_q.push_back(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
    exp_q.push_back(dr);
  endtask

  task automatic strobe(input logic [3:0] ct, input logic [3:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    in_strobe = 1'b1; in_cyctype_dir = ct; in_data_size = sz; in_addr = a; in_data = d;
    @(posedge lpc_clock); #1;
    in_strobe = 1'b0;
  endtask

  // Byte scoreboard plus hold-stability check, sampled on the falling edge.
  task automatic monitor();
    logic       hold = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge lpc_clock);
      if (!lpc_reset) begin
        hold = 1'b0;
      end else begin
        if (hold) chk("hold_byte", {out_valid, out_byte}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", out_byte, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", out_byte, e);
          end
          nbytes++;
        end
        hold = out_valid && !out_ready;
        held = out_byte;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!stat_busy && exp_q.size() == 0) break;
      @(posedge lpc_clock); #1;
    end
    chk("idle_busy", stat_busy, 0);
    chk("idle_queue", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (out_valid) break;
      @(posedge lpc_clock); #1;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  vec_t vecs[5];

  initial begin
    int run;
    int start;
    vecs[0] = '{ct: 4'd0,  mask: 16'h0001, en: 1'b1, acc: 1'b1};
    vecs[1] = '{ct: 4'd2,  mask: 16'hFFFB, en: 1'b1, acc: 1'b0};
    vecs[2] = '{ct: 4'd15, mask: 16'h8000, en: 1'b1, acc: 1'b1};
    vecs[3] = '{ct: 4'd3,  mask: 16'hFFFF, en: 1'b0, acc: 1'b0};
    vecs[4] = '{ct: 4'd7,  mask: 16'h0080, en: 1'b1, acc: 1'b1};

    lpc_reset = 1'b0; in_strobe = 1'b0; in_cyctype_dir = '0; in_addr = '0; in_data = '0;
    in_data_size = '0; cfg_enable = 1'b1; cfg_ctdir_mask = 16'h0001; out_ready = 1'b1;
    fork monitor(); join_none
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_level", stat_level, 0);
    chk("rst_overflow", stat_overflow, 0);
    chk("rst_busy", stat_busy, 0);
    repeat (2) @(posedge lpc_clock);
    #1 lpc_reset = 1'b1;
    @(posedge lpc_clock); #1;

    // Test 1: latency and contiguous 11-byte frame
    push_frame(4'd0, 4'd1, 32'h0000_7FE5, 32'h0000_006C, 8'h00);
    strobe(4'd0, 4'd1, 32'h0000_7FE5, 32'h0000_006C);
    chk("t1_valid_n1", out_valid, 0);
    @(posedge lpc_clock); #1;
    chk("t1_valid_n2", out_valid, 1);
    chk("t1_sync_n2", out_byte, 8'h5A);
    run = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge lpc_clock); #1;
      if (out_valid) run++;
    end
    chk("t1_run", run, 11);
    @(posedge lpc_clock); #1;
    chk("t1_valid_after", out_valid, 0);
    wait_idle(20);

    // Filter table (includes the masked ctdir=2 case)
    foreach (vecs[k]) begin
      cfg_ctdir_mask = vecs[k].mask;
      cfg_enable     = vecs[k].en;
      if (vecs[k].acc) push_frame(vecs[k].ct, 4'd4, 32'hA000_0000 + k, 32'h1234_5600 + k, 8'h00);
      strobe(vecs[k].ct, 4'd4, 32'hA000_0000 + k, 32'h1234_5600 + k);
      chk($sformatf("vec%0d_level", k), stat_level, {2'b00, vecs[k].acc});
      chk($sformatf("vec%0d_busy", k), stat_busy, vecs[k].acc);
      if (!vecs[k].acc) begin
        run = 0;
        for (int i = 0; i < 3; i++) begin
          @(posedge lpc_clock); #1;
          run += int'(out_valid) + int'(stat_level) + int'(stat_busy);
        end
        chk($sformatf("vec%0d_quiet", k), run, 0);
      end
      wait_idle(30);
    end
    cfg_enable = 1'b1; cfg_ctdir_mask = 16'hFFFF;

    // Test 3: ready toggling, each byte held while ready low
    push_frame(4'd0, 4'd1, 32'h0000_7FE5, 32'h0000_006C, 8'h00);
    out_ready = 1'b0;
    strobe(4'd0, 4'd1, 32'h0000_7FE5, 32'h0000_006C);
    for (int i = 0; i < 60; i++) begin
      if (!stat_busy && exp_q.size() == 0) break;
      @(posedge lpc_clock); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_idle(20);

    // Test 5: two records back to back -> 22 contiguous bytes
    push_frame(4'd1, 4'd2, 32'h1111_2222, 32'h3333_4444, 8'h00);
    push_frame(4'd2, 4'd4, 32'h5555_6666, 32'h7777_8888, 8'h00);
    strobe(4'd1, 4'd2, 32'h1111_2222, 32'h3333_4444);
    strobe(4'd2, 4'd4, 32'h5555_6666, 32'h7777_8888);
    wait_valid(10);
    run = 1;
    for (int i = 0; i < 21; i++) begin
      @(posedge lpc_clock); #1;
      if (out_valid) run++;
    end
    chk("t5_run", run, 22);
    @(posedge lpc_clock); #1;
    chk("t5_valid_after", out_valid, 0);
    wait_idle(20);

    // Test 4: overflow. One record sits in the frame register, four fill
    // the FIFO, the sixth and seventh are dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) push_frame(4'd1, 4'd1, 32'h100 + i, 32'h200 + i, 8'h00);
      strobe(4'd1, 4'd1, 32'h100 + i, 32'h200 + i);
    end
    chk("t4_level_full", stat_level, 4);
    chk("t4_overflow", stat_overflow, 1);
    chk("t4_busy_full", stat_busy, 1);
    out_ready = 1'b1;
    wait_idle(100);
    push_frame(4'd3, 4'd1, 32'h0000_0080, 32'h0000_00EE, 8'h02);
    strobe(4'd3, 4'd1, 32'h0000_0080, 32'h0000_00EE);
    wait_idle(30);
    chk("t4_overflow_sticky", stat_overflow, 1);

    // Test 6: reset while byte 5 is on the wire
    push_frame(4'd0, 4'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 8'h00);
    start = nbytes;
    strobe(4'd0, 4'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    for (int i = 0; i < 30; i++) begin
      if (nbytes >= start + 5) break;
      @(negedge lpc_clock);
    end
    chk("t6_reach_byte5", nbytes - start, 5);
    @(posedge lpc_clock); #2;
    chk("t6_byte5", out_byte, 8'hEF);
    lpc_reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_level", stat_level, 0);
    chk("t6_overflow", stat_overflow, 0);
    chk("t6_busy", stat_busy, 0);
    @(posedge lpc_clock); #3;
    lpc_reset = 1'b1;
    @(posedge lpc_clock); #1;
    push_frame(4'd5, 4'd2, 32'h0BAD_F00D, 32'h0000_1234, 8'h00);
    strobe(4'd5, 4'd2, 32'h0BAD_F00D, 32'h0000_1234);
    @(posedge lpc_clock); #1;
    chk("t6_sync_after", out_byte, 8'h5A);
    wait_idle(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
